// File: rtl/spi_sd_ctrl_if.sv
// CPU register-access bus for spi_sd_ctrl: one-cycle strobe, direction, register
// select, write data and combinational read data.
interface spi_sd_ctrl_if;
  logic       STB;
  logic       RW;
  logic [1:0] RS;
  logic [7:0] DIN;
  logic [7:0] DOUT;

  modport master (output STB, RW, RS, DIN, input DOUT);
  modport slave  (input STB, RW, RS, DIN, output DOUT);
endinterface

// File: rtl/spi_sd_ctrl.sv
// SPI mode-0 byte engine for two SD card slots behind a strobed 4-register CPU port.
// Define SPI_IRQ_EN to build the IE/DONE completion interrupt on nIRQ.
module spi_sd_ctrl #(
  parameter logic [7:0] DIV_RST = 8'd59
) (
  input  logic         MHZ48,
  input  logic         nRES,
  spi_sd_ctrl_if.slave bus,
  output logic         SCLK,
  output logic         MOSI,
  input  logic         MISO,
  output logic         nSD0,
  output logic         nSD1,
  output logic         nIRQ
);

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, reload_q, reload_d, div_q, div_d;
  logic [7:0] shift_q, shift_d, rx_q, rx_d;
  logic [2:0] bit_q, bit_d;
  logic       miso_q, miso_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic       ovr_q, ovr_d, auto_q, auto_d, nsd0_q, nsd0_d, nsd1_q, nsd1_d;
  logic       ie_q;
  logic       data_wr, data_rd, ctrl_wr, ctrl_rd, div_wr, busy, start, xfer_last;

  assign data_wr   = bus.STB && !bus.RW && (bus.RS == 2'd0);
  assign data_rd   = bus.STB &&  bus.RW && (bus.RS == 2'd0);
  assign ctrl_wr   = bus.STB && !bus.RW && (bus.RS == 2'd1);
  assign ctrl_rd   = bus.STB &&  bus.RW && (bus.RS == 2'd1);
  assign div_wr    = bus.STB && !bus.RW && (bus.RS == 2'd2);
  assign busy      = (state_q != ST_IDLE);
  assign start     = !busy && (data_wr || (data_rd && auto_q));
  assign xfer_last = (state_q == ST_HI) && (cnt_q == 8'd0) && (bit_q == 3'd7);

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    miso_d   = miso_q;
    rx_d     = rx_q;
    div_d    = div_wr ? bus.DIN : div_q;
    ovr_d    = ovr_q;
    auto_d   = auto_q;
    nsd0_d   = nsd0_q;
    nsd1_d   = nsd1_q;

    if (ctrl_rd)         ovr_d = 1'b0;
    if (data_wr && busy) ovr_d = 1'b1;  // overrun flag: set wins over the read-clear
    if (ctrl_wr) begin
      nsd0_d = bus.DIN[0];
      nsd1_d = bus.DIN[1];
      auto_d = bus.DIN[2];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LO;
          shift_d  = data_wr ? bus.DIN : 8'hFF;
          reload_d = div_q;
          cnt_d    = div_q;
          bit_d    = 3'd0;
        end
      end
      ST_LO: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HI;
          cnt_d   = reload_q;
          miso_d  = MISO;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HI: begin
        // The sampled bit joins the shifter only on exit so TX[0] survives until its turn.
        if (xfer_last) begin
          state_d = ST_IDLE;
          rx_d    = {shift_q[6:0], miso_q};
        end else if (cnt_q == 8'd0) begin
          state_d = ST_LO;
          shift_d = {shift_q[6:0], miso_q};
          bit_d   = bit_q + 3'd1;
          cnt_d   = reload_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sclk_d = (state_d == ST_HI);
    mosi_d = (state_d == ST_IDLE) ? 1'b1 : shift_d[7];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge MHZ48 or negedge nRES) begin
    if (!nRES) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      reload_q <= 8'd0;
      div_q    <= DIV_RST;
      shift_q  <= 8'hFF;
      rx_q     <= 8'hFF;
      bit_q    <= 3'd0;
      miso_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      ovr_q    <= 1'b0;
      auto_q   <= 1'b0;
      nsd0_q   <= 1'b1;
      nsd1_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      div_q    <= div_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      miso_q   <= miso_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ovr_q    <= ovr_d;
      auto_q   <= auto_d;
      nsd0_q   <= nsd0_d;
      nsd1_q   <= nsd1_d;
    end
  end

`ifdef SPI_IRQ_EN
  logic ie_r, done_q, nirq_q;

  always_ff @(posedge MHZ48 or negedge nRES) begin
    if (!nRES) begin
      ie_r   <= 1'b0;
      done_q <= 1'b0;
      nirq_q <= 1'b1;
    end else begin
      if (ctrl_wr) ie_r <= bus.DIN[3];
      if (xfer_last) begin
        done_q <= 1'b1;
      end else if (data_rd || data_wr || (ctrl_wr && !bus.DIN[3])) begin
        done_q <= 1'b0;
      end
      nirq_q <= ~(done_q & ie_r);
    end
  end

  assign ie_q = ie_r;
  assign nIRQ = nirq_q;
`else
  assign ie_q = 1'b0;
  assign nIRQ = 1'b1;
`endif

  always_comb begin
    case (bus.RS)
      2'd0:    bus.DOUT = rx_q;
      2'd1:    bus.DOUT = {busy, ovr_q, 2'b00, ie_q, auto_q, nsd1_q, nsd0_q};
      2'd2:    bus.DOUT = div_q;
      default: bus.DOUT = 8'h00;
    endcase
  end

  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign nSD0 = nsd0_q;
  assign nSD1 = nsd1_q;

endmodule

// File: tb/tb_spi_sd_ctrl.sv
// Self-checking bench for spi_sd_ctrl: register vectors, directed corner sequences and
// randomized transfers checked against a byte-level model of the SPI link.
module tb_spi_sd_ctrl;

  logic       clk = 1'b0;
  logic       nres = 1'b0;
  logic       sclk, mosi, miso, nsd0, nsd1, nirq;
  logic       miso_echo = 1'b1;
  logic       miso_bit = 1'b1;
  logic [7:0] miso_pat = 8'h00;
  bit         irq_mon_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  spi_sd_ctrl_if ifc ();

  spi_sd_ctrl #(.DIV_RST(8'd59)) dut (
    .MHZ48(clk), .nRES(nres), .bus(ifc), .SCLK(sclk), .MOSI(mosi),
    .MISO(miso), .nSD0(nsd0), .nSD1(nsd1), .nIRQ(nirq)
  );

  assign miso = miso_echo ? mosi : miso_bit;

  always #5 clk = ~clk;

`ifdef SPI_IRQ_EN
  localparam logic [7:0] CTRL_ALL = 8'h0F;
`else
  localparam logic [7:0] CTRL_ALL = 8'h07;
`endif

  // Link monitor: records MOSI at each SCLK rise and the length of every SCLK high/low phase.
  int unsigned cyc = 0;
  bit          mon_bits[$];
  int          hi_runs[$];
  int          lo_runs[$];
  int          hi_run = 0, lo_run = 0, irq_low = 0;
  int          bit_base = 0, hi_base = 0, lo_base = 0;
  logic        sclk_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int k;
    if (sclk) begin
      if (!sclk_prev) begin
        if (mon_bits.size() > bit_base) lo_runs.push_back(lo_run);
        mon_bits.push_back(mosi);
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (sclk_prev) begin
        hi_runs.push_back(hi_run);
        lo_run = 0;
      end
      lo_run++;
    end
    sclk_prev = sclk;
    k = mon_bits.size() - bit_base;
    miso_bit = (k >= 0 && k < 8) ? miso_pat[3'(7 - k)] : 1'b1;
    if (irq_mon_en && nirq !== 1'b1) irq_low++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_mark();
    bit_base = mon_bits.size();
    hi_base  = hi_runs.size();
    lo_base  = lo_runs.size();
  endtask

  task automatic cpu_wr(input logic [1:0] rs, input logic [7:0] d);
    @(negedge clk);
    ifc.STB = 1'b1; ifc.RW = 1'b0; ifc.RS = rs; ifc.DIN = d;
    @(negedge clk);
    ifc.STB = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] rs, output logic [7:0] d);
    @(negedge clk);
    ifc.STB = 1'b1; ifc.RW = 1'b1; ifc.RS = rs;
    #1 d = ifc.DOUT;
    @(negedge clk);
    ifc.STB = 1'b0;
  endtask

  // Polls CTRL.BUSY every cycle; returns the cycle stamp of the first sample showing it clear.
  task automatic poll_busy_end(output int unsigned c_end);
    int n;
    ifc.STB = 1'b1; ifc.RW = 1'b1; ifc.RS = 2'd1;
    for (n = 0; n < 20000; n++) begin
      #1;
      if (!ifc.DOUT[7]) break;
      @(negedge clk);
    end
    c_end = cyc;
    ifc.STB = 1'b0;
    if (n >= 20000) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_bits(input int n);
    int t;
    for (t = 0; t < 20000; t++) begin
      if (mon_bits.size() - bit_base >= n) break;
      @(negedge clk);
    end
    if (t >= 20000) check("bit_wait_timeout", 32'd1, 32'd0);
  endtask

  // Model of one byte on the wire: 8 pulses, MSB-first TX, every phase DIV+1 clocks long.
  task automatic check_stream(input string tag, input logic [7:0] exp_tx, input int d);
    logic [7:0] got = 8'h00;
    int nb, bad_hi = 0, bad_lo = 0;
    nb = mon_bits.size() - bit_base;
    check({tag, " pulses"}, 32'(nb), 32'd8);
    for (int i = 0; i < nb && i < 8; i++) got = {got[6:0], mon_bits[bit_base + i]};
    check({tag, " mosi_byte"}, 32'(got), 32'(exp_tx));
    for (int i = hi_base; i < hi_runs.size(); i++) if (hi_runs[i] != d + 1) bad_hi++;
    for (int i = lo_base; i < lo_runs.size(); i++) if (lo_runs[i] != d + 1) bad_lo++;
    check({tag, " hi_phases"}, 32'(hi_runs.size() - hi_base), 32'd8);
    check({tag, " hi_len_errs"}, 32'(bad_hi), 32'd0);
    check({tag, " lo_len_errs"}, 32'(bad_lo), 32'd0);
  endtask

  task automatic run_xfer(input string tag, input int d, input logic [7:0] tx,
                          input logic [7:0] pat, input logic echo, input logic [1:0] cs);
    int unsigned c0, c1;
    logic [7:0]  v;
    cpu_wr(2'd1, {6'd0, cs});
    cpu_wr(2'd2, 8'(d));
    miso_echo = echo;
    miso_pat  = pat;
    @(posedge clk);
    #1 mon_mark();
    cpu_wr(2'd0, tx);
    c0 = cyc;
    poll_busy_end(c1);
    check({tag, " busy_len"}, 32'(c1 - c0), 32'(16 * (d + 1)));
    check_stream(tag, tx, d);
    check({tag, " cs"}, 32'({nsd1, nsd0}), 32'(cs));
    cpu_rd(2'd0, v);
    check({tag, " rx"}, 32'(v), 32'(echo ? tx : pat));
  endtask

  typedef struct {
    logic       rw;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[13];
    logic [7:0]  v;
    int unsigned c0, c1;

    vecs = '{
      '{1'b1, 2'd0, 8'h00, 8'hFF}, '{1'b1, 2'd1, 8'h00, 8'h03},
      '{1'b1, 2'd2, 8'h00, 8'd59}, '{1'b1, 2'd3, 8'h00, 8'h00},
      '{1'b0, 2'd2, 8'h5A, 8'h00}, '{1'b1, 2'd2, 8'h00, 8'h5A},
      '{1'b0, 2'd3, 8'h77, 8'h00}, '{1'b1, 2'd3, 8'h00, 8'h00},
      '{1'b1, 2'd2, 8'h00, 8'h5A}, '{1'b0, 2'd1, 8'hFF, 8'h00},
      '{1'b1, 2'd1, 8'h00, CTRL_ALL}, '{1'b0, 2'd1, 8'h03, 8'h00},
      '{1'b1, 2'd1, 8'h00, 8'h03}
    };

    ifc.STB = 1'b0; ifc.RW = 1'b0; ifc.RS = 2'd0; ifc.DIN = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    check("rst sclk", 32'(sclk), 32'd0);
    check("rst mosi", 32'(mosi), 32'd1);
    check("rst cs", 32'({nsd1, nsd0}), 32'd3);
    check("rst nirq", 32'(nirq), 32'd1);
    nres = 1'b1;
    irq_mon_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rw) begin
        cpu_rd(vecs[i].rs, v);
        check($sformatf("vec%0d rs%0d", i, vecs[i].rs), 32'(v), 32'(vecs[i].exp));
      end else begin
        cpu_wr(vecs[i].rs, vecs[i].din);
      end
    end

    // DIV=0 echo transfer on slot 0
    run_xfer("t2", 0, 8'hA5, 8'h00, 1'b1, 2'b10);

    // Overrun: DATA write mid-byte is ignored, OVR reads once
    cpu_wr(2'd2, 8'd3);
    miso_echo = 1'b1;
    @(posedge clk);
    #1 mon_mark();
    cpu_wr(2'd0, 8'h3C);
    c0 = cyc;
    wait_bits(5);
    cpu_wr(2'd0, 8'h11);
    cpu_rd(2'd1, v);
    check("t3 busy_ovr", 32'(v[7:6]), 32'd3);
    cpu_rd(2'd1, v);
    check("t3 ovr_cleared", 32'(v[6]), 32'd0);
    poll_busy_end(c1);
    check("t3 busy_len", 32'(c1 - c0), 32'd64);
    check_stream("t3", 8'h3C, 3);
    cpu_rd(2'd0, v);
    check("t3 rx", 32'(v), 32'h3C);

    // AUTO: DATA read launches a 0xFF transfer
    cpu_wr(2'd2, 8'd0);
    cpu_wr(2'd1, 8'h06);
    miso_echo = 1'b0;
    miso_pat  = 8'h00;
    @(posedge clk);
    #1 mon_mark();
    cpu_rd(2'd0, v);
    c0 = cyc;
    check("t4 first_rx", 32'(v), 32'h3C);
    cpu_rd(2'd1, v);
    check("t4 busy", 32'(v[7]), 32'd1);
    poll_busy_end(c1);
    check("t4 busy_len", 32'(c1 - c0), 32'd16);
    check_stream("t4", 8'hFF, 0);
    cpu_rd(2'd0, v);
    check("t4 rx", 32'(v), 32'h00);
    cpu_wr(2'd1, 8'h02);
    poll_busy_end(c1);

    for (int i = 0; i < 6; i++) begin
      int         d;
      logic [7:0] tx, pat;
      logic [1:0] cs;
      d   = int'($urandom_range(0, 3));
      tx  = 8'($urandom);
      pat = 8'($urandom);
      cs  = 2'($urandom_range(0, 3));
      run_xfer($sformatf("rnd%0d", i), d, tx, pat, 1'b0, cs);
    end

    // Reset mid-transfer
    cpu_wr(2'd1, 8'h00);
    cpu_wr(2'd2, 8'd1);
    miso_echo = 1'b1;
    @(posedge clk);
    #1 mon_mark();
    cpu_wr(2'd0, 8'h96);
    wait_bits(3);
    #1 nres = 1'b0;
    #1;
    check("t5 sclk", 32'(sclk), 32'd0);
    check("t5 mosi", 32'(mosi), 32'd1);
    check("t5 cs", 32'({nsd1, nsd0}), 32'd3);
    ifc.STB = 1'b1; ifc.RW = 1'b1; ifc.RS = 2'd1;
    #1 check("t5 ctrl", 32'(ifc.DOUT), 32'h03);
    ifc.RS = 2'd0;
    #1 check("t5 rx", 32'(ifc.DOUT), 32'hFF);
    ifc.STB = 1'b0;
    @(negedge clk);
    #2 nres = 1'b1;
    run_xfer("t5b", 1, 8'h5E, 8'hC3, 1'b0, 2'b01);

`ifdef SPI_IRQ_EN
    cpu_wr(2'd2, 8'd0);
    cpu_wr(2'd1, 8'h0A);
    miso_echo = 1'b1;
    cpu_wr(2'd0, 8'h00);
    poll_busy_end(c1);
    check("t6 nirq_at_done", 32'(nirq), 32'd1);
    @(negedge clk);
    #1 check("t6 nirq_fall", 32'(nirq), 32'd0);
    cpu_rd(2'd0, v);
    check("t6 nirq_hold", 32'(nirq), 32'd0);
    @(negedge clk);
    #1 check("t6 nirq_rise", 32'(nirq), 32'd1);
`else
    cpu_wr(2'd2, 8'd0);
    cpu_wr(2'd1, 8'h0A);
    cpu_rd(2'd1, v);
    check("t6 ie_absent", 32'(v), 32'h02);
    cpu_wr(2'd0, 8'h00);
    poll_busy_end(c1);
    repeat (3) @(negedge clk);
    check("t6 nirq_never_low", 32'(irq_low), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
